// File: rtl/anti_park_mc_pkg.sv
// Shared Q-format constants, mode encodings and saturation helper for anti_park_mc.
package anti_park_mc_pkg;

    // Per-sample transform selection
    localparam logic MODE_INV_PARK = 1'b0;
    localparam logic MODE_FWD_PARK = 1'b1;

    // Full-scale trig value in Q1.(tw-1): 2^(tw-1)-1
    function automatic int trig_one(input int unsigned tw);
        return (32'sd1 <<< (tw - 32'd1)) - 32'sd1;
    endfunction

    // Half-LSB rounding offset added before the >>> (tw-1) rescale
    function automatic int round_const(input int unsigned tw);
        return 32'sd1 <<< (tw - 32'd2);
    endfunction

    // Returns {below_min, above_max} for a signed value against a width-bit signed range
    function automatic logic [1:0] sat_flags(input logic signed [63:0] val,
                                             input int unsigned         width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 32'd1));
        return {val < lo, val > hi};
    endfunction

endpackage

// File: rtl/anti_park_mc_sincos_lut.sv
// Quarter-wave sin/cos lookup with quadrant folding; two registered stages.
module anti_park_mc_sincos_lut
    import anti_park_mc_pkg::*;
#(
    parameter int unsigned THETA_WIDTH    = 16,
    parameter int unsigned TRIG_WIDTH     = 16,
    parameter int unsigned LUT_ADDR_WIDTH = 10
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [THETA_WIDTH-1:0]         theta,
    output logic signed [TRIG_WIDTH-1:0]   sin,
    output logic signed [TRIG_WIDTH-1:0]   cos
);

    localparam int unsigned DEPTH = 32'd1 << LUT_ADDR_WIDTH;
    localparam int unsigned PH_W  = LUT_ADDR_WIDTH + 2;
    localparam int unsigned NA_W  = LUT_ADDR_WIDTH + 1;
    localparam logic signed [TRIG_WIDTH-1:0] ONE = TRIG_WIDTH'(trig_one(TRIG_WIDTH));
    localparam real HALF_PI = 1.5707963267948966;

    logic signed [TRIG_WIDTH-1:0] w_rom [DEPTH];
    logic [PH_W-1:0]              w_phase;
    logic [1:0]                   w_quad;
    logic [LUT_ADDR_WIDTH-1:0]    w_addr;
    logic [NA_W-1:0]              w_naddr;
    logic signed [TRIG_WIDTH-1:0] w_t_a;
    logic signed [TRIG_WIDTH-1:0] w_t_na;
    logic signed [TRIG_WIDTH-1:0] w_sin;
    logic signed [TRIG_WIDTH-1:0] w_cos;
    logic                         w_unused_lsbs;

    logic signed [TRIG_WIDTH-1:0] r_t_a;
    logic signed [TRIG_WIDTH-1:0] r_t_na;
    logic [1:0]                   r_quad;
    logic signed [TRIG_WIDTH-1:0] r_sin;
    logic signed [TRIG_WIDTH-1:0] r_cos;

    // Quarter-wave table: entry i = round(ONE * sin(i * (pi/2) / DEPTH))
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam real ANG = HALF_PI * real'(gi) / real'(DEPTH);
        localparam int  VAL = $rtoi(real'(trig_one(TRIG_WIDTH)) * $sin(ANG) + 0.5);
        assign w_rom[gi] = TRIG_WIDTH'(VAL);
    end

    // Phase index is the top bits of theta; the rest is truncated
    assign w_phase       = theta[THETA_WIDTH-1 -: PH_W];
    assign w_quad        = w_phase[PH_W-1 -: 2];
    assign w_addr        = w_phase[LUT_ADDR_WIDTH-1:0];
    assign w_naddr       = NA_W'(DEPTH) - NA_W'(w_addr);
    assign w_unused_lsbs = ^theta[THETA_WIDTH-PH_W-1:0];

    // Read sin(a) and sin(90deg - a); index DEPTH is the exact full-scale point
    always_comb begin
        w_t_a  = w_rom[w_addr];
        w_t_na = w_rom[w_naddr[LUT_ADDR_WIDTH-1:0]];
        if (w_naddr[LUT_ADDR_WIDTH]) begin
            w_t_na = ONE;
        end
    end

    // Stage 1: table read register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_t_a  <= '0;
            r_t_na <= '0;
            r_quad <= '0;
        end else if (enable) begin
            r_t_a  <= w_t_a;
            r_t_na <= w_t_na;
            r_quad <= w_quad;
        end
    end

    // Quadrant folding: swap and negate the two table reads
    always_comb begin
        w_sin = r_t_a;
        w_cos = r_t_na;
        case (r_quad)
            2'd0: begin w_sin =  r_t_a;  w_cos =  r_t_na; end
            2'd1: begin w_sin =  r_t_na; w_cos = -r_t_a;  end
            2'd2: begin w_sin = -r_t_a;  w_cos = -r_t_na; end
            default: begin w_sin = -r_t_na; w_cos = r_t_a; end
        endcase
    end

    // Stage 2: folded sin/cos register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sin <= '0;
            r_cos <= '0;
        end else if (enable) begin
            r_sin <= w_sin;
            r_cos <= w_cos;
        end
    end

    assign sin = r_sin;
    assign cos = r_cos;

endmodule

// File: rtl/anti_park_mc.sv
// Multi-channel pipelined inverse/forward Park transform with valid/ready streaming.
module anti_park_mc
    import anti_park_mc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 18,
    parameter int unsigned THETA_WIDTH    = 16,
    parameter int unsigned TRIG_WIDTH     = 16,
    parameter int unsigned LUT_ADDR_WIDTH = 10,
    parameter int unsigned N_CHANNELS     = 4,
    parameter int unsigned CH_WIDTH       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [THETA_WIDTH-1:0]       in_theta,
    input  logic signed [DATA_WIDTH-1:0] in_x,
    input  logic signed [DATA_WIDTH-1:0] in_y,
    input  logic                         in_mode,
    input  logic [CH_WIDTH-1:0]          in_channel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_u,
    output logic signed [DATA_WIDTH-1:0] out_v,
    output logic [CH_WIDTH-1:0]          out_channel,
    output logic                         out_sat
);

    localparam int unsigned PROD_W = TRIG_WIDTH + DATA_WIDTH;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned SHIFT  = TRIG_WIDTH - 1;
    localparam logic signed [SUM_W-1:0]      RND   = SUM_W'(round_const(TRIG_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                         w_adv;
    logic                         w_accept;
    logic signed [TRIG_WIDTH-1:0] w_sin;
    logic signed [TRIG_WIDTH-1:0] w_cos;
    logic signed [SUM_W-1:0]      w_sum_u;
    logic signed [SUM_W-1:0]      w_sum_v;
    logic signed [SUM_W-1:0]      w_shr_u;
    logic signed [SUM_W-1:0]      w_shr_v;
    logic signed [63:0]           w_ext_u;
    logic signed [63:0]           w_ext_v;
    logic [1:0]                   w_flags_u;
    logic [1:0]                   w_flags_v;
    logic signed [DATA_WIDTH-1:0] w_u_clip;
    logic signed [DATA_WIDTH-1:0] w_v_clip;

    logic                         r_v1, r_v2, r_v3;
    logic signed [DATA_WIDTH-1:0] r_x1, r_x2, r_y1, r_y2;
    logic                         r_m1, r_m2, r_m3;
    logic [CH_WIDTH-1:0]          r_ch1, r_ch2, r_ch3;
    logic signed [PROD_W-1:0]     r_p_cx, r_p_sy, r_p_sx, r_p_cy;

    // Single advance enable: every stage moves unless the output is held
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;
    assign w_accept = in_valid & w_adv;

    anti_park_mc_sincos_lut #(
        .THETA_WIDTH    (THETA_WIDTH),
        .TRIG_WIDTH     (TRIG_WIDTH),
        .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH)
    ) u_lut (
        .clock  (clock),
        .reset  (reset),
        .enable (w_adv),
        .theta  (in_theta),
        .sin    (w_sin),
        .cos    (w_cos)
    );

    // S1-S2: operands, mode and tag delayed to line up with the LUT output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_y1  <= '0;
            r_y2  <= '0;
            r_m1  <= MODE_INV_PARK;
            r_m2  <= MODE_INV_PARK;
            r_ch1 <= '0;
            r_ch2 <= '0;
        end else if (w_adv) begin
            r_v1  <= w_accept;
            r_v2  <= r_v1;
            r_x1  <= in_x;
            r_x2  <= r_x1;
            r_y1  <= in_y;
            r_y2  <= r_y1;
            r_m1  <= in_mode;
            r_m2  <= r_m1;
            r_ch1 <= in_channel;
            r_ch2 <= r_ch1;
        end
    end

    // S3: the four signed trig x data products
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_v3   <= 1'b0;
            r_m3   <= MODE_INV_PARK;
            r_ch3  <= '0;
            r_p_cx <= '0;
            r_p_sy <= '0;
            r_p_sx <= '0;
            r_p_cy <= '0;
        end else if (w_adv) begin
            r_v3   <= r_v2;
            r_m3   <= r_m2;
            r_ch3  <= r_ch2;
            r_p_cx <= PROD_W'(w_cos) * PROD_W'(r_x2);
            r_p_sy <= PROD_W'(w_sin) * PROD_W'(r_y2);
            r_p_sx <= PROD_W'(w_sin) * PROD_W'(r_x2);
            r_p_cy <= PROD_W'(w_cos) * PROD_W'(r_y2);
        end
    end

    // S4: rotation direction chosen by mode
    always_comb begin
        w_sum_u = '0;
        w_sum_v = '0;
        case (r_m3)
            MODE_INV_PARK: begin
                w_sum_u = SUM_W'(r_p_cx) - SUM_W'(r_p_sy);
                w_sum_v = SUM_W'(r_p_sx) + SUM_W'(r_p_cy);
            end
            MODE_FWD_PARK: begin
                w_sum_u = SUM_W'(r_p_cx) + SUM_W'(r_p_sy);
                w_sum_v = SUM_W'(r_p_cy) - SUM_W'(r_p_sx);
            end
            default: begin
                w_sum_u = '0;
                w_sum_v = '0;
            end
        endcase
    end

    // Round half-up, rescale out of Q1.(TRIG_WIDTH-1), then clip to the data range
    assign w_shr_u   = (w_sum_u + RND) >>> SHIFT;
    assign w_shr_v   = (w_sum_v + RND) >>> SHIFT;
    assign w_ext_u   = {{(64-SUM_W){w_shr_u[SUM_W-1]}}, w_shr_u};
    assign w_ext_v   = {{(64-SUM_W){w_shr_v[SUM_W-1]}}, w_shr_v};
    assign w_flags_u = sat_flags(w_ext_u, DATA_WIDTH);
    assign w_flags_v = sat_flags(w_ext_v, DATA_WIDTH);
    assign w_u_clip  = w_flags_u[0] ? D_MAX : (w_flags_u[1] ? D_MIN : w_shr_u[DATA_WIDTH-1:0]);
    assign w_v_clip  = w_flags_v[0] ? D_MAX : (w_flags_v[1] ? D_MIN : w_shr_v[DATA_WIDTH-1:0]);

    // Output register; holds while downstream stalls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_u       <= '0;
            out_v       <= '0;
            out_channel <= '0;
            out_sat     <= 1'b0;
        end else if (w_adv) begin
            out_valid   <= r_v3;
            out_u       <= w_u_clip;
            out_v       <= w_v_clip;
            out_channel <= r_ch3;
            out_sat     <= r_v3 & ((|w_flags_u) | (|w_flags_v));
        end
    end

endmodule

// File: tb/tb_anti_park_mc.sv
// Directed self-checking bench for anti_park_mc.
module tb_anti_park_mc;

    logic               clock;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_theta;
    logic signed [17:0] in_x;
    logic signed [17:0] in_y;
    logic               in_mode;
    logic [1:0]         in_channel;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] out_u;
    logic signed [17:0] out_v;
    logic [1:0]         out_channel;
    logic               out_sat;

    int checks   = 0;
    int failures = 0;

    anti_park_mc dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_theta    (in_theta),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_mode     (in_mode),
        .in_channel  (in_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_u       (out_u),
        .out_v       (out_v),
        .out_channel (out_channel),
        .out_sat     (out_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Absolute time bound on the whole run
    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Drive one sample with out_ready high and wait (bounded) for its result
    task automatic run_one(input logic [15:0] th, input int x, input int y,
                           input logic m, input logic [1:0] ch,
                           output int u, output int v, output logic [1:0] och,
                           output logic sat, output int lat);
        @(negedge clock);
        out_ready  = 1'b1;
        in_theta   = th;
        in_x       = 18'(x);
        in_y       = 18'(y);
        in_mode    = m;
        in_channel = ch;
        in_valid   = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        u   = int'(out_u);
        v   = int'(out_v);
        och = out_channel;
        sat = out_sat;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_theta = '0; in_x = '0; in_y = '0; in_mode = 1'b0; in_channel = '0;
        repeat (2) @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_u !== 18'sd0) begin failures++; $display("FAIL reset_out_u got=%0d want=0", out_u); end
        checks++; if (out_v !== 18'sd0) begin failures++; $display("FAIL reset_out_v got=%0d want=0", out_v); end
        checks++; if (out_channel !== 2'd0) begin failures++; $display("FAIL reset_out_channel got=%0d want=0", out_channel); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%b want=0", out_sat); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_inverse_basic;
        int u, v, lat; logic [1:0] och; logic sat;
        run_one(16'h0000, 1000, 0, 1'b0, 2'd2, u, v, och, sat, lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL basic_latency got=%0d want=4", lat); end
        checks++; if (u != 1000) begin failures++; $display("FAIL basic_u got=%0d want=1000", u); end
        checks++; if (v != 0) begin failures++; $display("FAIL basic_v got=%0d want=0", v); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL basic_sat got=%b want=0", sat); end
        checks++; if (och !== 2'd2) begin failures++; $display("FAIL basic_channel got=%0d want=2", och); end
    endtask

    task automatic test_quadrants;
        int u, v, lat; logic [1:0] och; logic sat;
        run_one(16'h4000, 1000, 500, 1'b0, 2'd1, u, v, och, sat, lat);
        checks++; if (u != -500 || v != 1000 || och !== 2'd1) begin failures++; $display("FAIL inv_90 got u=%0d v=%0d ch=%0d want u=-500 v=1000 ch=1", u, v, och); end
        run_one(16'hC000, 1000, 500, 1'b0, 2'd3, u, v, och, sat, lat);
        checks++; if (u != 500 || v != -1000 || och !== 2'd3) begin failures++; $display("FAIL inv_270 got u=%0d v=%0d ch=%0d want u=500 v=-1000 ch=3", u, v, och); end
        run_one(16'h4000, 1000, 500, 1'b1, 2'd0, u, v, och, sat, lat);
        checks++; if (u != 500 || v != -1000) begin failures++; $display("FAIL fwd_90 got u=%0d v=%0d want u=500 v=-1000", u, v); end
        run_one(16'h8000, 1000, 500, 1'b0, 2'd2, u, v, och, sat, lat);
        checks++; if (u != -1000 || v != -500) begin failures++; $display("FAIL inv_180 got u=%0d v=%0d want u=-1000 v=-500", u, v); end
        // Last phase step before wrap: sin=-50, cos=32767
        run_one(16'hFFFF, 1000, 0, 1'b0, 2'd0, u, v, och, sat, lat);
        checks++; if (u != 1000 || v != -2) begin failures++; $display("FAIL wrap_ffff got u=%0d v=%0d want u=1000 v=-2", u, v); end
    endtask

    task automatic test_saturation;
        int u, v, lat; logic [1:0] och; logic sat;
        run_one(16'h2000, 131071, 131071, 1'b0, 2'd1, u, v, och, sat, lat);
        checks++; if (u != 0 || v != 131071) begin failures++; $display("FAIL sat_inv_val got u=%0d v=%0d want u=0 v=131071", u, v); end
        checks++; if (sat !== 1'b1) begin failures++; $display("FAIL sat_inv_flag got=%b want=1", sat); end
        run_one(16'h2000, -131072, -131072, 1'b1, 2'd2, u, v, och, sat, lat);
        checks++; if (u != -131072 || v != 0) begin failures++; $display("FAIL sat_fwd_val got u=%0d v=%0d want u=-131072 v=0", u, v); end
        checks++; if (sat !== 1'b1) begin failures++; $display("FAIL sat_fwd_flag got=%b want=1", sat); end
    endtask

    task automatic test_back_to_back;
        int ex[8], ey[8], eu[8], ev[8];
        int n_in, n_out;
        logic prev_stall;
        logic [38:0] snap;
        int k;
        for (int i = 0; i < 8; i++) begin
            ex[i] = 100 * (i + 1);
            ey[i] = -30 * (i + 1) - 7;
            k = i % 4;
            case (k)
                0: begin eu[i] =  ex[i]; ev[i] =  ey[i]; end
                1: begin eu[i] = -ey[i]; ev[i] =  ex[i]; end
                2: begin eu[i] = -ex[i]; ev[i] = -ey[i]; end
                default: begin eu[i] = ey[i]; ev[i] = -ex[i]; end
            endcase
        end
        n_in = 0; n_out = 0; prev_stall = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
            @(negedge clock);
            if (prev_stall) begin
                checks++;
                if ({out_valid, out_u, out_v, out_channel, out_sat} !== {1'b1, snap}) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got u=%0d v=%0d ch=%0d want u=%0d v=%0d", cyc, out_u, out_v, out_channel, $signed(snap[38:21]), $signed(snap[20:3]));
                end
            end
            out_ready = !(cyc >= 5 && cyc < 8);
            if (n_in < 8) begin
                in_theta   = {2'(n_in % 4), 14'd0};
                in_x       = 18'(ex[n_in]);
                in_y       = 18'(ey[n_in]);
                in_mode    = 1'b0;
                in_channel = 2'(n_in % 4);
                in_valid   = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_u != 18'(eu[n_out]) || out_v != 18'(ev[n_out]) || out_channel !== 2'(n_out % 4) || out_sat !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_result idx=%0d got u=%0d v=%0d ch=%0d want u=%0d v=%0d ch=%0d", n_out, out_u, out_v, out_channel, eu[n_out], ev[n_out], n_out % 4);
                end
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
            prev_stall = out_valid && !out_ready;
            snap = {out_u, out_v, out_channel, out_sat};
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (n_out != 8) begin failures++; $display("FAIL stream_count got=%0d want=8", n_out); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_extra got out_valid=%b want=0", out_valid); end
    endtask

    task automatic test_round_trip;
        int x, y, fu, fv, ru, rv, lat1, lat2;
        logic [15:0] th;
        logic [1:0] och;
        logic sat;
        for (int i = 0; i < 64; i++) begin
            th = 16'($urandom);
            x  = int'($urandom_range(16382, 0)) - 8191;
            y  = int'($urandom_range(16382, 0)) - 8191;
            run_one(th, x, y, 1'b1, 2'(i % 4), fu, fv, och, sat, lat1);
            run_one(th, fu, fv, 1'b0, 2'(i % 4), ru, rv, och, sat, lat2);
            checks++;
            if (lat1 != 4 || lat2 != 4 || iabs(ru - x) > 2 || iabs(rv - y) > 2) begin
                failures++;
                $display("FAIL round_trip i=%0d th=%h got x=%0d y=%0d lat=%0d/%0d want x=%0d y=%0d (+/-2) lat=4", i, th, ru, rv, lat1, lat2, x, y);
            end
        end
    endtask

    task automatic test_async_reset;
        int u, v, lat, stale;
        logic [1:0] och;
        logic sat;
        @(negedge clock);
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_theta   = 16'h0000;
            in_x       = 18'(10 * (k + 1));
            in_y       = 18'sd0;
            in_mode    = 1'b0;
            in_channel = 2'(k);
            in_valid   = 1'b1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL prereset_valid got=%b want=1", out_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_u !== 18'sd0 || out_channel !== 2'd0) begin
            failures++; $display("FAIL async_reset got valid=%b u=%0d ch=%0d want valid=0 u=0 ch=0", out_valid, out_u, out_channel);
        end
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL stale_after_reset got=%0d valid cycles want=0", stale); end
        run_one(16'h0000, 777, -333, 1'b0, 2'd1, u, v, och, sat, lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL post_reset_latency got=%0d want=4", lat); end
        checks++; if (u != 777 || v != -333 || och !== 2'd1) begin failures++; $display("FAIL post_reset_value got u=%0d v=%0d ch=%0d want u=777 v=-333 ch=1", u, v, och); end
    endtask

    initial begin
        test_reset();
        test_inverse_basic();
        test_quadrants();
        test_saturation();
        test_back_to_back();
        test_round_trip();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
